// File: rtl/ram_seq_pkg.sv
// Shared types for the RAM fill/scan sequencer: FSM states and read-mode constants.
package ram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } seq_state_t;

  localparam int RD_LOOP = 0;
  localparam int RD_ONCE = 1;

endpackage

// File: rtl/ram_dwell_cnt.sv
// Dwell counter: counts 0..CNT_MAX-1 while enabled and flags the terminal count
// combinationally so the sequencer can advance the address on the same edge it wraps.
module ram_dwell_cnt #(
  parameter int CNT_MAX = 24_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc = en && !clr && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencer for a single-port synchronous RAM: fills it with a seeded incrementing
// pattern, then scans it back with a programmable dwell per address. All outputs registered.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int CNT_MAX = 24_999_999,
  parameter int RD_MODE = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_flag,
  input  logic              rd_flag,
  input  logic [DATA_W-1:0] wr_seed,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_wrap
);

  // Wrap is explicit so DEPTH need not be a power of two.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic [DATA_W-1:0] seed_reg, seed_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              wr_en_reg, wr_en_next;
  logic              rd_en_reg, rd_en_next;
  logic              busy_reg, busy_next;
  logic              wr_done_reg, wr_done_next;
  logic              rd_wrap_reg, rd_wrap_next;
  logic              dwell_tc;

  assign addr_inc = addr_reg + ADDR_W'(1);

  // Counter is held clear outside READ, so every scan entry starts a fresh dwell.
  ram_dwell_cnt #(
    .CNT_MAX (CNT_MAX)
  ) u_dwell (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (state_reg != READ),
    .en    (state_reg == READ),
    .tc    (dwell_tc)
  );

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wr_data_next = wr_data_reg;
    seed_next    = seed_reg;
    rd_pend_next = rd_pend_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    wr_done_next = 1'b0;
    rd_wrap_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wr_flag) begin
          state_next   = WRITE;
          seed_next    = wr_seed;
          addr_next    = '0;
          wr_data_next = wr_seed;
          wr_en_next   = 1'b1;
          rd_pend_next = rd_flag;
        end else if (rd_flag) begin
          state_next = READ;
          addr_next  = '0;
          rd_en_next = 1'b1;
        end
      end

      WRITE: begin
        if (addr_reg == LAST_ADDR) begin
          addr_next    = '0;
          wr_done_next = 1'b1;
          rd_pend_next = 1'b0;
          if (rd_pend_reg || rd_flag) begin
            state_next = READ;
            rd_en_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          addr_next    = addr_inc;
          wr_data_next = DATA_W'(addr_inc) + seed_reg;
          wr_en_next   = 1'b1;
          rd_pend_next = rd_pend_reg | rd_flag;
        end
      end

      READ: begin
        if (wr_flag) begin
          // A write request aborts the scan; a same-cycle read flag queues a rescan.
          state_next   = WRITE;
          seed_next    = wr_seed;
          addr_next    = '0;
          wr_data_next = wr_seed;
          wr_en_next   = 1'b1;
          rd_pend_next = rd_flag;
        end else if (rd_flag) begin
          state_next = IDLE;
          addr_next  = '0;
        end else begin
          rd_en_next = 1'b1;
          if (dwell_tc) begin
            if (addr_reg == LAST_ADDR) begin
              addr_next    = '0;
              rd_wrap_next = 1'b1;
              if (RD_MODE == RD_ONCE) begin
                state_next = IDLE;
                rd_en_next = 1'b0;
              end
            end else begin
              addr_next = addr_inc;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      seed_reg    <= '0;
      rd_pend_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      wr_done_reg <= 1'b0;
      rd_wrap_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wr_data_reg <= wr_data_next;
      seed_reg    <= seed_next;
      rd_pend_reg <= rd_pend_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      busy_reg    <= busy_next;
      wr_done_reg <= wr_done_next;
      rd_wrap_reg <= rd_wrap_next;
    end
  end

  assign wr_en   = wr_en_reg;
  assign rd_en   = rd_en_reg;
  assign addr    = addr_reg;
  assign wr_data = wr_data_reg;
  assign busy    = busy_reg;
  assign wr_done = wr_done_reg;
  assign rd_wrap = rd_wrap_reg;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl: a looping and a single-pass instance share stimulus;
// a RAM model with registered read hangs off the looping instance.
module tb_ram_seq_ctrl;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 16;
  localparam int CNT_MAX = 10;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              wr_flag;
  logic              rd_flag;
  logic [DATA_W-1:0] wr_seed;

  logic              wr_en_l, rd_en_l, busy_l, wr_done_l, rd_wrap_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wr_data_l;
  logic              wr_en_o, rd_en_o, busy_o, wr_done_o, rd_wrap_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wr_data_o;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;

  int checks   = 0;
  int failures = 0;

  // Observation vector: {wr_en, rd_en, busy, wr_done, rd_wrap, addr, wr_data}
  logic [20:0] obs_l, obs_o, exp_l, exp_o;
  assign obs_l = {wr_en_l, rd_en_l, busy_l, wr_done_l, rd_wrap_l, addr_l, wr_data_l};
  assign obs_o = {wr_en_o, rd_en_o, busy_o, wr_done_o, rd_wrap_o, addr_o, wr_data_o};

  ram_seq_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_MAX(CNT_MAX), .RD_MODE(0)
  ) dut_loop (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_flag(wr_flag), .rd_flag(rd_flag),
    .wr_seed(wr_seed), .wr_en(wr_en_l), .rd_en(rd_en_l), .addr(addr_l),
    .wr_data(wr_data_l), .busy(busy_l), .wr_done(wr_done_l), .rd_wrap(rd_wrap_l)
  );

  ram_seq_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_MAX(CNT_MAX), .RD_MODE(1)
  ) dut_once (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_flag(wr_flag), .rd_flag(rd_flag),
    .wr_seed(wr_seed), .wr_en(wr_en_o), .rd_en(rd_en_o), .addr(addr_o),
    .wr_data(wr_data_o), .busy(busy_o), .wr_done(wr_done_o), .rd_wrap(rd_wrap_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (wr_en_l) mem[addr_l] <= wr_data_l;
    else if (rd_en_l) rd_q <= mem[addr_l];
  end

  function automatic logic [20:0] vec(input logic we, input logic re, input logic bz,
                                      input logic wd, input logic rw, input int a,
                                      input logic [7:0] d);
    return {we, re, bz, wd, rw, 8'(a), d};
  endfunction

  task automatic do_reset();
    sys_rst_n = 1'b0;
    wr_flag   = 1'b0;
    rd_flag   = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    wr_flag   = 1'b0;
    rd_flag   = 1'b0;
    wr_seed   = 8'h00;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (obs_l !== 21'h0) begin failures++; $display("FAIL reset_loop: got %h expected %h", obs_l, 21'h0); end
    checks++;
    if (obs_o !== 21'h0) begin failures++; $display("FAIL reset_once: got %h expected %h", obs_o, 21'h0); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (obs_l !== 21'h0) begin failures++; $display("FAIL reset_idle: got %h expected %h", obs_l, 21'h0); end
    $display("test_reset done");
  endtask

  task automatic test_write();
    logic [7:0] d;
    wr_seed = 8'h05;
    wr_flag = 1'b1;
    @(negedge sys_clk);
    wr_flag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h05 + 8'(i);
      exp_l = vec(1, 0, 1, 0, 0, i, d);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL write_%0d: got %h expected %h", i, obs_l, exp_l); end
      @(negedge sys_clk);
    end
    exp_l = vec(0, 0, 0, 1, 0, 0, 8'h14);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL write_done: got %h expected %h", obs_l, exp_l); end
    @(negedge sys_clk);
    exp_l = vec(0, 0, 0, 0, 0, 0, 8'h14);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL write_after: got %h expected %h", obs_l, exp_l); end
    $display("test_write seed=05 done");
  endtask

  // Continuous loop on dut_loop and single pass on dut_once from the same rd_flag.
  task automatic test_read_modes();
    rd_flag = 1'b1;
    @(negedge sys_clk);
    rd_flag = 1'b0;
    for (int c = 0; c <= 185; c++) begin
      exp_l = vec(0, 1, 1, 0, (c == 160), (c / 10) % 16, 8'h14);
      if (c < 160)       exp_o = vec(0, 1, 1, 0, 0, c / 10, 8'h14);
      else if (c == 160) exp_o = vec(0, 0, 0, 0, 1, 0, 8'h14);
      else               exp_o = vec(0, 0, 0, 0, 0, 0, 8'h14);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL read_loop_c%0d: got %h expected %h", c, obs_l, exp_l); end
      checks++;
      if (obs_o !== exp_o) begin failures++; $display("FAIL read_once_c%0d: got %h expected %h", c, obs_o, exp_o); end
      if (c == 185) rd_flag = 1'b1;
      @(negedge sys_clk);
    end
    rd_flag = 1'b0;
    exp_l = vec(0, 0, 0, 0, 0, 0, 8'h14);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL read_stop: got %h expected %h", obs_l, exp_l); end
    exp_o = vec(0, 1, 1, 0, 0, 0, 8'h14);
    checks++;
    if (obs_o !== exp_o) begin failures++; $display("FAIL once_restart: got %h expected %h", obs_o, exp_o); end
    $display("test_read_modes done");
  endtask

  task automatic test_write_then_read();
    logic [7:0] d;
    do_reset();
    wr_seed = 8'hF0;
    wr_flag = 1'b1;
    rd_flag = 1'b1;
    @(negedge sys_clk);
    wr_flag = 1'b0;
    rd_flag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'hF0 + 8'(i);
      exp_l = vec(1, 0, 1, 0, 0, i, d);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL wr_rd_write_%0d: got %h expected %h", i, obs_l, exp_l); end
      @(negedge sys_clk);
    end
    for (int c = 0; c <= 160; c++) begin
      exp_l = vec(0, 1, 1, (c == 0), (c == 160), (c / 10) % 16, 8'hFF);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL wr_rd_read_c%0d: got %h expected %h", c, obs_l, exp_l); end
      if (c % 10 == 5) begin
        d = 8'hF0 + 8'(c / 10);
        checks++;
        if (rd_q !== d) begin failures++; $display("FAIL ram_data_a%0d: got %h expected %h", c / 10, rd_q, d); end
      end
      @(negedge sys_clk);
    end
    $display("test_write_then_read seed=F0 done");
  endtask

  task automatic test_abort();
    logic [7:0] d;
    do_reset();
    wr_seed = 8'h30;
    wr_flag = 1'b1;
    @(negedge sys_clk);
    wr_flag = 1'b0;
    repeat (DEPTH + 1) @(negedge sys_clk);
    rd_flag = 1'b1;
    @(negedge sys_clk);
    rd_flag = 1'b0;
    for (int c = 0; c <= 73; c++) begin
      exp_l = vec(0, 1, 1, 0, 0, c / 10, 8'h3F);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL abort_read_c%0d: got %h expected %h", c, obs_l, exp_l); end
      if (c == 73) begin
        wr_seed = 8'h40;
        wr_flag = 1'b1;
      end
      @(negedge sys_clk);
    end
    wr_flag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h40 + 8'(i);
      exp_l = vec(1, 0, 1, 0, 0, i, d);
      checks++;
      if (obs_l !== exp_l) begin failures++; $display("FAIL abort_write_%0d: got %h expected %h", i, obs_l, exp_l); end
      rd_flag = (i == 4);
      @(negedge sys_clk);
    end
    rd_flag = 1'b0;
    exp_l = vec(0, 1, 1, 1, 0, 0, 8'h4F);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL abort_resume: got %h expected %h", obs_l, exp_l); end
    @(negedge sys_clk);
    exp_l = vec(0, 1, 1, 0, 0, 0, 8'h4F);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL abort_reading: got %h expected %h", obs_l, exp_l); end
    $display("test_abort seed=40 done");
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    wr_seed = 8'h11;
    wr_flag = 1'b1;
    @(negedge sys_clk);
    wr_flag = 1'b0;
    repeat (9) @(negedge sys_clk);
    exp_l = vec(1, 0, 1, 0, 0, 9, 8'h1A);
    checks++;
    if (obs_l !== exp_l) begin failures++; $display("FAIL midwr_pre: got %h expected %h", obs_l, exp_l); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (obs_l !== 21'h0) begin failures++; $display("FAIL midwr_async_loop: got %h expected %h", obs_l, 21'h0); end
    checks++;
    if (obs_o !== 21'h0) begin failures++; $display("FAIL midwr_async_once: got %h expected %h", obs_o, 21'h0); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      checks++;
      if (obs_l !== 21'h0) begin failures++; $display("FAIL midwr_idle_c%0d: got %h expected %h", c, obs_l, 21'h0); end
    end
    $display("test_reset_mid_write done");
  endtask

  initial begin
    sys_rst_n = 1'b0;
    wr_flag   = 1'b0;
    rd_flag   = 1'b0;
    wr_seed   = '0;
    test_reset();
    test_write();
    test_read_modes();
    test_write_then_read();
    test_abort();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
